alu_result_fifo: RTL and testbench

Capture queue directly downstream of the registered 4-bit ALU stage. It samples the ALU's 8-bit result on a capture strobe and tags each entry with its opcode and status flags. Entries are held in a small first-word-fall-through FIFO, so a slower consumer (pin readout or a later accumulator) can drain results at its own pace. Overflow and underflow are recorded as sticky errors, never silently corrupted state.

---
 rtl/alu_result_fifo.sv | 109 ++++++++++
 tb/tb_alu_result_fifo.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// alu_result_fifo
//   Capture queue behind the registered 4-bit ALU stage. On each cap strobe
//   the 8-bit result is stored together with its opcode and derived status
//   flags {inv, div0, zero}. The queue is first-word-fall-through, so the
//   oldest entry is always presented on head_*. A dropped push sets ovf, and
//   a pop on an empty queue sets udf. Both flags stay set until rst or clr.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   clr               synchronous flush, same effect as rst
//   cap               push strobe: capture alu_result/alu_op/alu_b this edge
//   alu_result[7:0]   registered ALU result
//   alu_op[2:0]       opcode that produced alu_result
//   alu_b[3:0]        b operand that produced alu_result (used for div0)
//   pop               pop strobe: discard the head entry this edge
//   head_valid        queue non-empty
//   head_data/op/flags  oldest entry; forced to 0 when empty
//   count[PTRW:0]     occupancy 0..DEPTH
//   full              count == DEPTH
//   ovf, udf          sticky overflow / underflow
module alu_result_fifo #(
  parameter int DEPTH = 4,
  localparam int PTRW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            cap,
  input  logic [7:0]      alu_result,
  input  logic [2:0]      alu_op,
  input  logic [3:0]      alu_b,
  input  logic            pop,
  output logic            head_valid,
  output logic [7:0]      head_data,
  output logic [2:0]      head_op,
  output logic [2:0]      head_flags,
  output logic [PTRW:0]   count,
  output logic            full,
  output logic            ovf,
  output logic            udf
);

  localparam logic [PTRW:0] FULL_CNT = (PTRW+1)'(DEPTH);

  typedef struct packed {
    logic [2:0] op;
    logic       inv;
    logic       div0;
    logic       zero;
    logic [7:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PTRW-1:0] wr_ptr, rd_ptr;
  logic            flush;
  logic            push_ok, pop_ok;
  entry_t          wr_entry, head;

  assign flush = rst | clr;

  // A push into a full queue is still taken when the head leaves on the same
  // edge; in that case wr_ptr == rd_ptr and the slot being overwritten is the
  // one being popped.
  assign pop_ok  = pop & (count != '0);
  assign push_ok = cap & (~full | pop);

  always_comb begin
    wr_entry      = '0;
    wr_entry.op   = alu_op;
    wr_entry.inv  = alu_op[2] & alu_op[1];
    wr_entry.div0 = (alu_op == 3'b101) && (alu_b == 4'h0);
    wr_entry.zero = (alu_result == 8'h00);
    wr_entry.data = alu_result;
  end

  // Storage has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!flush && push_ok) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (cap && !push_ok)        ovf <= 1'b1;
      if (pop && (count == '0))   udf <= 1'b1;
    end
  end

  // Outputs depend on registered state only.
  assign head_valid = (count != '0);
  assign full       = (count == FULL_CNT);
  assign head       = head_valid ? mem[rd_ptr] : '0;
  assign head_data  = head.data;
  assign head_op    = head.op;
  assign head_flags = {head.inv, head.div0, head.zero};

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, clr, cap, pop;
  logic [7:0] alu_result;
  logic [2:0] alu_op;
  logic [3:0] alu_b;
  logic       head_valid, full, ovf, udf;
  logic [7:0] head_data;
  logic [2:0] head_op, head_flags;
  logic [2:0] count;

  int n_chk = 0;
  int n_err = 0;

  alu_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .cap(cap), .alu_result(alu_result),
    .alu_op(alu_op), .alu_b(alu_b), .pop(pop), .head_valid(head_valid),
    .head_data(head_data), .head_op(head_op), .head_flags(head_flags),
    .count(count), .full(full), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one clock; inputs are changed and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic [2:0] op, input logic [3:0] b,
                      input logic with_pop);
    cap = 1'b1; pop = with_pop; alu_result = d; alu_op = op; alu_b = b;
    step();
    cap = 1'b0; pop = 1'b0;
  endtask

  task automatic do_pop();
    pop = 1'b1;
    step();
    pop = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [7:0] d, input logic [2:0] op,
                          input logic [2:0] fl);
    chk({tag, "_data"},  head_data, d);
    chk({tag, "_op"},    head_op, op);
    chk({tag, "_flags"}, head_flags, fl);
  endtask

  // reference flag formula {inv, div0, zero}
  function automatic logic [2:0] ref_flags(input logic [7:0] d, input logic [2:0] op,
                                           input logic [3:0] b);
    return {op[2] & op[1], (op == 3'b101) && (b == 4'h0), d == 8'h00};
  endfunction

  typedef struct { logic [7:0] d; logic [2:0] op; logic [2:0] fl; } ent_t;

  initial begin
    ent_t q[$];
    logic m_ovf, m_udf;
    rst = 1'b1; clr = 1'b0; cap = 1'b0; pop = 1'b0;
    alu_result = '0; alu_op = '0; alu_b = '0;
    step(); step();
    rst = 1'b0;

    // reset state
    chk("rst_count", count, 0);
    chk("rst_valid", head_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_udf", udf, 0);
    chk_head("rst_head", 8'h00, 3'b000, 3'b000);

    // three tagged pushes and drain
    push(8'h07, 3'b010, 4'h4, 1'b0);
    chk("t1_first_valid", head_valid, 1);
    chk("t1_first_data", head_data, 8'h07);
    push(8'h00, 3'b011, 4'h4, 1'b0);
    push(8'hFF, 3'b101, 4'h0, 1'b0);
    chk("t1_count", count, 3);
    chk_head("t1_h0", 8'h07, 3'b010, 3'b000);
    do_pop();
    chk_head("t1_h1", 8'h00, 3'b011, 3'b001);
    do_pop();
    chk_head("t1_h2", 8'hFF, 3'b101, 3'b010);
    do_pop();
    chk("t1_empty_count", count, 0);
    chk_head("t1_empty", 8'h00, 3'b000, 3'b000);

    // overflow: fill then push while full
    for (int i = 1; i <= 4; i++) push(8'(i), 3'b001, 4'h1, 1'b0);
    chk("t2_full", full, 1);
    chk("t2_ovf_before", ovf, 0);
    push(8'h05, 3'b001, 4'h1, 1'b0);
    chk("t2_ovf", ovf, 1);
    chk("t2_count", count, 4);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_drain", head_data, 32'(i));
      do_pop();
    end
    chk("t2_valid_end", head_valid, 0);
    chk("t2_ovf_sticky", ovf, 1);
    do_clr();
    chk("t2_clr_ovf", ovf, 0);

    // full queue, simultaneous push and pop
    for (int i = 1; i <= 4; i++) push(8'h10 + 8'(i), 3'b000, 4'h2, 1'b0);
    push(8'hAA, 3'b001, 4'h3, 1'b1);
    chk("t3_count", count, 4);
    chk("t3_ovf", ovf, 0);
    for (int i = 2; i <= 4; i++) begin
      chk("t3_drain", head_data, 32'(8'h10 + 8'(i)));
      do_pop();
    end
    chk("t3_drain_last", head_data, 8'hAA);
    do_pop();
    chk("t3_empty", count, 0);

    // underflow, then pop+cap on empty
    do_pop();
    chk("t4_udf", udf, 1);
    chk("t4_count", count, 0);
    chk("t4_valid", head_valid, 0);
    push(8'h55, 3'b000, 4'h0, 1'b1);
    chk("t4_count1", count, 1);
    chk("t4_data", head_data, 8'h55);

    // invalid opcode flag, then clr with cap
    do_pop();
    push(8'h3C, 3'b110, 4'h5, 1'b0);
    chk_head("t5_inv", 8'h3C, 3'b110, 3'b100);
    chk("t5_udf_sticky", udf, 1);
    clr = 1'b1; cap = 1'b1; alu_result = 8'h99; alu_op = 3'b000;
    step();
    clr = 1'b0; cap = 1'b0;
    chk("t5_count", count, 0);
    chk("t5_ovf", ovf, 0);
    chk("t5_udf", udf, 0);
    chk("t5_valid", head_valid, 0);

    // random traffic against a queue model
    q.delete();
    m_ovf = 1'b0; m_udf = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      int pc;
      bit pu_ok, po_ok;
      pc = ((c / 200) % 2 == 0) ? 70 : 30;
      cap = ($urandom_range(99) < pc);
      pop = ($urandom_range(99) < (100 - pc));
      alu_result = 8'($urandom_range(255));
      if ($urandom_range(7) == 0) alu_result = 8'h00;
      alu_op = 3'($urandom_range(7));
      alu_b  = 4'($urandom_range(15));
      if (alu_op == 3'b101 && $urandom_range(1) == 0) alu_b = 4'h0;
      pu_ok = cap && (q.size() < DEPTH || pop);
      po_ok = pop && q.size() > 0;
      if (cap && !pu_ok) m_ovf = 1'b1;
      if (pop && q.size() == 0) m_udf = 1'b1;
      if (po_ok) void'(q.pop_front());
      if (pu_ok) q.push_back('{alu_result, alu_op, ref_flags(alu_result, alu_op, alu_b)});
      step();
      chk("r_count", count, q.size());
      chk("r_count_le", count <= DEPTH, 1);
      chk("r_full", full, q.size() == DEPTH);
      chk("r_valid", head_valid, q.size() != 0);
      chk("r_ovf", ovf, m_ovf);
      chk("r_udf", udf, m_udf);
      if (q.size() != 0) chk_head("r_head", q[0].d, q[0].op, q[0].fl);
      else chk_head("r_head0", 8'h00, 3'b000, 3'b000);
    end
    cap = 1'b0; pop = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
